rf_write_sequencer: RTL and testbench

Write-side front end for the 12 x 24-bit register file. Accepts writeback results from the ALU and memory-load producers over valid/ready handshakes, arbitrates them round-robin into a small in-order queue, and drives the register file write port (`we3`/`ra3`/`wd3`) at one write per cycle. Also publishes a per-register pending mask and, optionally, a forwarding lookup port so the operand-fetch logic can detect in-flight writes.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_wq_fifo.sv | 58 +++++
 rtl/rf_write_sequencer.sv | 134 +++++++++++++
 tb/tb_rf_write_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry constants, the write record
// carried through the write queue, and the arbiter grant encoding.
package rf_pkg;
  localparam int RF_DATA_W   = 24;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 12;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;
endpackage

// File: rtl/rf_wq_fifo.sv
// In-order circular write queue. Every slot and its valid bit are exposed
// so the parent can scan in-flight writes without popping them.
import rf_pkg::*;

module rf_wq_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rf_wr_t                 push_data,
  input  logic                   pop,
  output rf_wr_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output rf_wr_t [DEPTH-1:0]     entries,
  output logic   [DEPTH-1:0]     valid,
  output logic   [PTR_W-1:0]     head
);
  rf_wr_t [DEPTH-1:0] mem;
  logic   [PTR_W-1:0] tail;
  logic               push_ok, pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[head];
  assign entries  = mem;

  // Pointers wrap naturally at DEPTH (power of two); valid bits track occupancy per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push_ok) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (pop_ok) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end
endmodule

// File: rtl/rf_write_sequencer.sv
// Register-file write front end: round-robin ALU/load arbitration into an
// in-order queue, one registered write per cycle, pending-register mask.
// Optional forwarding lookup is built when RF_WSEQ_FWD_EN is defined.
import rf_pkg::*;

module rf_write_sequencer #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                we3,
  output logic [ADDR_W-1:0]   ra3,
  output logic [DATA_W-1:0]   wd3,
  output logic [NUM_REGS-1:0] pending,
  output logic                err_addr,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  grant_e             last_grant;
  logic               full, empty, contest, acc_alu, acc_mem, accept, legal, push;
  rf_wr_t             acc_wr, pop_wr;
  rf_wr_t [DEPTH-1:0] entries;
  logic   [DEPTH-1:0] ent_vld;
  logic   [PTR_W-1:0] head;
  logic   [CNT_W-1:0] count;

  // A full queue blocks both producers; a contest goes to whoever lost last.
  assign contest   = alu_valid & mem_valid & ~full;
  assign alu_ready = ~full & ~(alu_valid & mem_valid & (last_grant == GRANT_ALU));
  assign mem_ready = ~full & ~(alu_valid & mem_valid & (last_grant == GRANT_MEM));
  assign acc_alu   = alu_valid & alu_ready;
  assign acc_mem   = mem_valid & mem_ready;
  assign accept    = acc_alu | acc_mem;
  assign legal     = int'(acc_wr.rd) < NUM_REGS;
  assign push      = accept & legal;

  // Select the accepted producer's record (grants are mutually exclusive).
  always_comb begin
    acc_wr.rd   = alu_rd;
    acc_wr.data = alu_data;
    if (acc_mem) begin
      acc_wr.rd   = mem_rd;
      acc_wr.data = mem_data;
    end
  end

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (acc_wr),
    .pop       (~empty),
    .pop_data  (pop_wr),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .entries   (entries),
    .valid     (ent_vld),
    .head      (head)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

  // Output stage drains the head every non-empty cycle; also tracks arbiter and error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3        <= 1'b0;
      ra3        <= '0;
      wd3        <= '0;
      err_addr   <= 1'b0;
      last_grant <= GRANT_ALU;
    end else begin
      we3 <= ~empty;
      if (!empty) begin
        ra3 <= pop_wr.rd;
        wd3 <= pop_wr.data;
      end
      if (accept && !legal) err_addr <= 1'b1;
      if (contest) last_grant <= acc_mem ? GRANT_MEM : GRANT_ALU;
    end
  end

  // Pending mask: OR of every queued destination plus the write being driven now.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = we3 && (int'(ra3) == r);
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && (int'(entries[i].rd) == r)) pending[r] = 1'b1;
      end
    end
  end

`ifdef RF_WSEQ_FWD_EN
  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so the youngest match overrides; output stage is oldest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (we3 && ra3 == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = wd3;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent_vld[idx] && entries[idx].rd == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end
`else
  logic fwd_unused;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
  assign fwd_unused = ^{fwd_addr, head};
`endif
endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
import rf_pkg::*;

module tb_rf_write_sequencer;
  localparam int DEPTH = 4;
  localparam int NREG  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [3:0]  alu_rd = '0, mem_rd = '0, fwd_addr = '0;
  logic [23:0] alu_data = '0, mem_data = '0;
  logic        we3, err_addr, fwd_hit;
  logic [3:0]  ra3;
  logic [23:0] wd3, fwd_data;
  logic [11:0] pending;

  rf_write_sequencer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .we3(we3), .ra3(ra3), .wd3(wd3), .pending(pending), .err_addr(err_addr),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model state
  rf_wr_t q[$];
  bit     m_we, m_err;
  bit     m_last_mem;          // 1: memory won the last contest
  logic [3:0]  m_ra;
  logic [23:0] m_wd;

  int grant_log[$];            // 1 = mem, 0 = alu, as seen on DUT readies
  int write_log[$];            // DUT ra3 whenever we3 is high

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [11:0] p;
    logic        h;
    logic [23:0] d;
    p = '0;
    if (m_we) p[m_ra] = 1'b1;
    foreach (q[i]) p[q[i].rd] = 1'b1;
    h = 1'b0;
    d = '0;
`ifdef RF_WSEQ_FWD_EN
    if (m_we && m_ra == fwd_addr) begin h = 1'b1; d = m_wd; end
    foreach (q[i]) if (q[i].rd == fwd_addr) begin h = 1'b1; d = q[i].data; end
`endif
    chk("we3", we3, m_we);
    chk("ra3", ra3, m_ra);
    chk("wd3", wd3, m_wd);
    chk("pending", pending, p);
    chk("err_addr", err_addr, m_err);
    chk("fwd_hit", fwd_hit, h);
    chk("fwd_data", fwd_data, d);
    if (we3 === 1'b1) write_log.push_back(int'(ra3));
  endtask

  // One clock: drive, check readies mid-cycle, advance model at the edge, check outputs.
  task automatic step(bit av, int ard, int adat, bit mv, int mrd, int mdat, bit r);
    bit full, ear, emr, acc;
    rf_wr_t w;
    rst       = r;
    alu_valid = av;  alu_rd = ard[3:0];  alu_data = adat[23:0];
    mem_valid = mv;  mem_rd = mrd[3:0];  mem_data = mdat[23:0];
    @(negedge clk);
    full = (q.size() >= DEPTH);
    ear  = !full && !(av && mv && !m_last_mem);
    emr  = !full && !(av && mv &&  m_last_mem);
    if (!r) begin
      chk("alu_ready", alu_ready, ear);
      chk("mem_ready", mem_ready, emr);
      if (mv && mem_ready) grant_log.push_back(1);
      else if (av && alu_ready) grant_log.push_back(0);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_we = 0; m_ra = '0; m_wd = '0; m_err = 0; m_last_mem = 0;
    end else begin
      acc = (av && ear) || (mv && emr);
      w.rd   = (mv && emr) ? mrd[3:0]  : ard[3:0];
      w.data = (mv && emr) ? mdat[23:0] : adat[23:0];
      if (av && mv && !full) m_last_mem = emr;
      m_we = (q.size() > 0);
      if (m_we) begin
        m_ra = q[0].rd;
        m_wd = q[0].data;
        q.delete(0);
      end
      if (acc) begin
        if (int'(w.rd) < NREG) q.push_back(w);
        else m_err = 1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset values
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("reset_ready_alu", alu_ready, 1);
    chk("reset_ready_mem", mem_ready, 1);

    // single ALU write: pending from edge N to N+2, we3 only in cycle N+1
    step(1, 3, 24'h00ABCD, 0, 0, 0, 0);
    chk("single_we3_n", we3, 0);
    chk("single_pend_n", pending, 12'h008);
    idle(1);
    chk("single_we3_n1", we3, 1);
    chk("single_ra3_n1", ra3, 3);
    chk("single_wd3_n1", wd3, 24'h00ABCD);
    chk("single_pend_n1", pending, 12'h008);
    idle(1);
    chk("single_we3_n2", we3, 0);
    chk("single_pend_n2", pending, 0);

    // contention: mem wins first, then alternation
    step(0, 0, 0, 0, 0, 0, 1);
    grant_log.delete();
    write_log.delete();
    for (int i = 0; i < 4; i++)
      step(1, 1 + (i / 2), 24'h100 + i, 1, 5 + (i / 2), 24'h500 + i, 0);
    idle(3);
    chk("grant_cnt", grant_log.size(), 4);
    chk("write_cnt", write_log.size(), 4);
    if (grant_log.size() == 4 && write_log.size() == 4) begin
      chk("grant0", grant_log[0], 1);
      chk("grant1", grant_log[1], 0);
      chk("grant2", grant_log[2], 1);
      chk("grant3", grant_log[3], 0);
      chk("write0", write_log[0], 5);
      chk("write1", write_log[1], 1);
      chk("write2", write_log[2], 6);
      chk("write3", write_log[3], 2);
    end

    // illegal destination: accepted, never written, sticky until reset
    write_log.delete();
    step(0, 0, 0, 1, 12, 24'h123456, 0);
    idle(20);
    chk("illegal_err_held", err_addr, 1);
    chk("illegal_no_write", write_log.size(), 0);
    chk("illegal_no_pend", pending, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("illegal_err_cleared", err_addr, 0);

    // forwarding: two writes to r7, youngest data visible until it retires
    fwd_addr = 4'd7;
    step(1, 7, 24'h000011, 0, 0, 0, 0);
    step(1, 7, 24'h000022, 0, 0, 0, 0);
`ifdef RF_WSEQ_FWD_EN
    chk("fwd_hit_young", fwd_hit, 1);
    chk("fwd_data_young", fwd_data, 24'h000022);
`else
    chk("fwd_hit_off", fwd_hit, 0);
`endif
    idle(2);
    chk("fwd_hit_retired", fwd_hit, 0);

    // reset mid-operation, including a handshake offered in the reset cycle
    for (int i = 0; i < 3; i++) step(1, i, 24'h700 + i, 1, 4 + i, 24'h800 + i, 0);
    step(1, 9, 24'hDEAD, 1, 10, 24'hBEEF, 1);
    chk("midrst_we3", we3, 0);
    chk("midrst_pend", pending, 0);
    write_log.delete();
    idle(4);
    chk("midrst_no_stale", write_log.size(), 0);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      fwd_addr = 4'($urandom_range(0, 15));
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 15), int'($urandom() & 32'hFFFFFF),
           bit'($urandom_range(0, 1)), $urandom_range(0, 15), int'($urandom() & 32'hFFFFFF),
           ($urandom_range(0, 63) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
